seg_pattern_decoder: RTL and testbench

Inverse of the seven-segment pattern ROM. It accepts a stream of 8-bit active-low segment patterns and decodes each into a 4-bit hex digit plus a decimal-point flag. Digits are packed into a right-aligned frame, and the frame is handed off when a blank pattern arrives. It sits between any pattern source (ROM readout, captured display bus) and logic that needs numeric values, such as a comparator or a BCD adder.

---
 rtl/seg_pattern_decoder.sv | 123 ++++++++++++
 tb/tb_seg_pattern_decoder.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_pattern_decoder.sv
// seg_pattern_decoder
// Decodes a stream of active-low seven-segment patterns back into hex digits
// and packs them right-aligned into a frame. A blank pattern closes the frame,
// which is then held until the consumer takes it.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   in_valid    in_seg valid this cycle
//   in_ready    decoder accepts a pattern (COLLECT state)
//   in_seg      active-low pattern, bit0=a .. bit6=g, bit7=dp
//   out_valid   frame available (HOLD state)
//   out_ready   consumer takes the frame
//   out_digits  packed digits, [3:0] is the most recent
//   out_dp      dp flag per digit, bit0 pairs with out_digits[3:0]
//   out_count   number of digits in the frame
//   out_err     frame saw an illegal pattern, overflow or orphan dp
module seg_pattern_decoder #(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_seg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NDIG-1:0] out_digits,
  output logic [NDIG-1:0]   out_dp,
  output logic [3:0]        out_count,
  output logic              out_err
);

  localparam logic [0:0] S_COLLECT = 1'b0;
  localparam logic [0:0] S_HOLD    = 1'b1;

  localparam logic [3:0] NDIG_CNT  = 4'(NDIG);
  localparam logic [7:0] PAT_DP    = 8'h7F;
  localparam logic [7:0] PAT_BLANK = 8'hFF;

  logic [0:0]        state;
  logic              hit;
  logic [3:0]        code;
  logic [4*NDIG-1:0] digits_next;
  logic [NDIG-1:0]   dp_next;

  // Segment-to-hex lookup; dp bit is handled separately.
  always_comb begin
    hit  = 1'b1;
    code = 4'h0;
    case (in_seg[6:0])
      7'h40: code = 4'h0;
      7'h79: code = 4'h1;
      7'h24: code = 4'h2;
      7'h30: code = 4'h3;
      7'h19: code = 4'h4;
      7'h12: code = 4'h5;
      7'h02: code = 4'h6;
      7'h78: code = 4'h7;
      7'h00: code = 4'h8;
      7'h10: code = 4'h9;
      7'h08: code = 4'hA;
      7'h03: code = 4'hB;
      7'h46: code = 4'hC;
      7'h21: code = 4'hD;
      7'h06: code = 4'hE;
      7'h0E: code = 4'hF;
      default: hit = 1'b0;
    endcase
  end

  // Shift-in written as shift-then-overwrite so NDIG=1 needs no empty slice.
  always_comb begin
    digits_next      = out_digits << 4;
    digits_next[3:0] = code;
    dp_next          = out_dp << 1;
    dp_next[0]       = ~in_seg[7];
  end

  assign in_ready  = (state == S_COLLECT);
  assign out_valid = (state == S_HOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_COLLECT;
      out_digits <= '0;
      out_dp     <= '0;
      out_count  <= '0;
      out_err    <= 1'b0;
    end else if (state == S_COLLECT) begin
      if (in_valid) begin
        if (hit) begin
          out_digits <= digits_next;
          out_dp     <= dp_next;
          if (out_count == NDIG_CNT)
            out_err <= 1'b1;          // oldest digit shifted out
          else
            out_count <= out_count + 4'd1;
        end else if (in_seg == PAT_DP) begin
          if (out_count == 4'd0)
            out_err <= 1'b1;          // dp with no digit to attach to
          else
            out_dp[0] <= 1'b1;
        end else if (in_seg == PAT_BLANK) begin
          // Leading blanks are skipped; an error-only frame is still reported.
          if ((out_count != 4'd0) || out_err)
            state <= S_HOLD;
        end else begin
          out_err <= 1'b1;
        end
      end
    end else begin
      if (out_ready) begin
        state      <= S_COLLECT;
        out_digits <= '0;
        out_dp     <= '0;
        out_count  <= '0;
        out_err    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_pattern_decoder.sv
module tb_seg_pattern_decoder;

  localparam int NDIG = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_seg;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_digits;
  logic [3:0]  out_dp;
  logic [3:0]  out_count;
  logic        out_err;

  int tests = 0;
  int fails = 0;

  seg_pattern_decoder #(.NDIG(NDIG)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_seg(in_seg),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_digits(out_digits), .out_dp(out_dp),
    .out_count(out_count), .out_err(out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Segment patterns (active low, without dp) for hex digits 0..F.
  logic [6:0] seg_tab [16];
  initial begin
    seg_tab[0]  = 7'h40; seg_tab[1]  = 7'h79; seg_tab[2]  = 7'h24; seg_tab[3]  = 7'h30;
    seg_tab[4]  = 7'h19; seg_tab[5]  = 7'h12; seg_tab[6]  = 7'h02; seg_tab[7]  = 7'h78;
    seg_tab[8]  = 7'h00; seg_tab[9]  = 7'h10; seg_tab[10] = 7'h08; seg_tab[11] = 7'h03;
    seg_tab[12] = 7'h46; seg_tab[13] = 7'h21; seg_tab[14] = 7'h06; seg_tab[15] = 7'h0E;
  end

  // Reference model: a list of decoded digits with their dp flags.
  int mq[$];
  bit mdp[$];
  bit merr;

  function automatic void model_clear();
    mq.delete();
    mdp.delete();
    merr = 1'b0;
  endfunction

  // Returns 1 when the pattern closes a frame.
  function automatic bit model_step(logic [7:0] p);
    int idx = -1;
    for (int i = 0; i < 16; i++)
      if (seg_tab[i] == p[6:0]) idx = i;
    if (idx >= 0) begin
      mq.push_back(idx);
      mdp.push_back(~p[7]);
      if (mq.size() > NDIG) begin
        void'(mq.pop_front());
        void'(mdp.pop_front());
        merr = 1'b1;
      end
      return 1'b0;
    end
    if (p == 8'h7F) begin
      if (mq.size() == 0) merr = 1'b1;
      else mdp[mdp.size()-1] = 1'b1;
      return 1'b0;
    end
    if (p == 8'hFF) return (mq.size() != 0) || merr;
    merr = 1'b1;
    return 1'b0;
  endfunction

  // {valid, ready, err, count, dp, digits}
  function automatic logic [26:0] model_vec();
    logic [15:0] d  = '0;
    logic [3:0]  dp = '0;
    int n = mq.size();
    for (int i = 0; i < n; i++) begin
      d     = d | (16'(mq[n-1-i]) << (4*i));
      dp[i] = mdp[n-1-i];
    end
    return {1'b1, 1'b0, merr, 4'(n), dp, d};
  endfunction

  function automatic logic [26:0] mk(bit v, bit r, bit e, int c, logic [3:0] dp, logic [15:0] d);
    return {v, r, e, 4'(c), dp, d};
  endfunction

  function automatic logic [26:0] dut_vec();
    return {out_valid, in_ready, out_err, out_count, out_dp, out_digits};
  endfunction

  function automatic logic [7:0] digit_pat(int d, bit dp_on);
    return {~dp_on, seg_tab[d]};
  endfunction

  // Presents one pattern until it is accepted (bounded wait).
  task automatic send(input logic [7:0] p);
    int budget = 20;
    in_valid = 1'b1;
    in_seg   = p;
    while (!in_ready && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (budget == 0) begin
      tests++; fails++;
      $display("FAIL send_timeout: pattern %02h never accepted, in_ready=%0b required 1", p, in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_out_ready();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [26:0] exp;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_seg = 8'h00;
    @(posedge clk); #1;
    exp = mk(0, 1, 0, 0, 4'h0, 16'h0);
    tests++;
    if (dut_vec() !== exp) begin
      fails++; $display("FAIL reset_first_edge: got %h required %h", dut_vec(), exp);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (dut_vec() !== exp) begin
      fails++; $display("FAIL reset_idle: got %h required %h", dut_vec(), exp);
    end
    model_clear();
  endtask

  task automatic test_basic_frame();
    logic [26:0] exp;
    send(8'hC0); send(8'hF9); send(8'hA4); send(8'hFF);
    exp = mk(1, 0, 0, 3, 4'h0, 16'h0012);
    tests++;
    if (dut_vec() !== exp) begin
      fails++; $display("FAIL basic_frame: got %h required %h", dut_vec(), exp);
    end
    pulse_out_ready();
    exp = mk(0, 1, 0, 0, 4'h0, 16'h0);
    tests++;
    if (dut_vec() !== exp) begin
      fails++; $display("FAIL basic_handshake: got %h required %h", dut_vec(), exp);
    end
  endtask

  task automatic test_dp_frame();
    logic [26:0] exp;
    send(8'hA1); send(8'h86); send(8'h40); send(8'h7F); send(8'hFF);
    exp = mk(1, 0, 0, 3, 4'h1, 16'h0DE0);
    tests++;
    if (dut_vec() !== exp) begin
      fails++; $display("FAIL dp_frame: got %h required %h", dut_vec(), exp);
    end
    pulse_out_ready();
    exp = mk(0, 1, 0, 0, 4'h0, 16'h0);
    tests++;
    if (dut_vec() !== exp) begin
      fails++; $display("FAIL dp_handshake: got %h required %h", dut_vec(), exp);
    end
  endtask

  task automatic test_leading_blanks();
    logic [26:0] exp;
    send(8'hFF); send(8'hFF);
    exp = mk(0, 1, 0, 0, 4'h0, 16'h0);
    tests++;
    if (dut_vec() !== exp) begin
      fails++; $display("FAIL leading_blank_ignored: got %h required %h", dut_vec(), exp);
    end
    send(8'h79); send(8'hFF);
    exp = mk(1, 0, 0, 1, 4'h1, 16'h0001);
    tests++;
    if (dut_vec() !== exp) begin
      fails++; $display("FAIL leading_blank_frame: got %h required %h", dut_vec(), exp);
    end
    pulse_out_ready();
  endtask

  task automatic test_overflow();
    logic [26:0] exp;
    for (int d = 1; d <= 6; d++) send(digit_pat(d, 1'b0));
    send(8'hFF);
    exp = mk(1, 0, 1, 4, 4'h0, 16'h3456);
    tests++;
    if (dut_vec() !== exp) begin
      fails++; $display("FAIL overflow: got %h required %h", dut_vec(), exp);
    end
    pulse_out_ready();
  endtask

  task automatic test_errors();
    logic [26:0] exp;
    send(8'h90); send(8'h55); send(8'h80); send(8'hFF);
    exp = mk(1, 0, 1, 2, 4'h0, 16'h0098);
    tests++;
    if (dut_vec() !== exp) begin
      fails++; $display("FAIL illegal_pattern: got %h required %h", dut_vec(), exp);
    end
    pulse_out_ready();
    send(8'h7F); send(8'hFF);
    exp = mk(1, 0, 1, 0, 4'h0, 16'h0);
    tests++;
    if (dut_vec() !== exp) begin
      fails++; $display("FAIL orphan_dp: got %h required %h", dut_vec(), exp);
    end
    pulse_out_ready();
  endtask

  task automatic test_backpressure_reset();
    logic [26:0] exp;
    send(digit_pat(5, 1'b1)); send(8'hFF);
    exp = mk(1, 0, 0, 1, 4'h1, 16'h0005);
    in_valid = 1'b1;
    in_seg   = 8'hF9;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      tests++;
      if (dut_vec() !== exp) begin
        fails++; $display("FAIL backpressure_cycle%0d: got %h required %h", c, dut_vec(), exp);
      end
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp = mk(0, 1, 0, 0, 4'h0, 16'h0);
    tests++;
    if (dut_vec() !== exp) begin
      fails++; $display("FAIL reset_in_hold: got %h required %h", dut_vec(), exp);
    end
    model_clear();
  endtask

  task automatic test_random();
    logic [26:0] exp;
    logic [7:0]  p;
    bit          done;
    bit          legal;
    for (int f = 0; f < 30; f++) begin
      model_clear();
      done = 1'b0;
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        void'(model_step(8'hFF));
        send(8'hFF);
      end
      for (int k = 0; k < int'($urandom_range(0, 7)); k++) begin
        case ($urandom_range(0, 9))
          7: p = 8'h7F;
          8: begin
            legal = 1'b1;
            while (legal) begin
              p = 8'($urandom);
              legal = (p[6:0] == 7'h7F);
              for (int i = 0; i < 16; i++)
                if (seg_tab[i] == p[6:0]) legal = 1'b1;
            end
          end
          default: p = digit_pat(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        endcase
        void'(model_step(p));
        send(p);
      end
      done = model_step(8'hFF);
      send(8'hFF);
      if (done) begin
        exp = model_vec();
        tests++;
        if (dut_vec() !== exp) begin
          fails++; $display("FAIL random_frame%0d: got %h required %h", f, dut_vec(), exp);
        end
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        tests++;
        if (dut_vec() !== exp) begin
          fails++; $display("FAIL random_hold%0d: got %h required %h", f, dut_vec(), exp);
        end
        pulse_out_ready();
      end
      exp = mk(0, 1, 0, 0, 4'h0, 16'h0);
      tests++;
      if (dut_vec() !== exp) begin
        fails++; $display("FAIL random_idle%0d: got %h required %h", f, dut_vec(), exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_seg = 8'h00;
    test_reset();
    test_basic_frame();
    test_dp_frame();
    test_leading_blanks();
    test_overflow();
    test_errors();
    test_backpressure_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
